// File: rtl/power_mult_scheduler.sv
// Round-robin front end sharing one iterative W-bit multiplier among NREQ requesters.
// Each accepted job (X, E) returns X^E mod 2^W tagged with the requester index.
module power_mult_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int EW   = 3,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    x_in,
  input  logic [NREQ*EW-1:0]   exp_in,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [W-1:0]         res_data
);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [W-1:0]      base_q, base_d;
  logic [EW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic [IDW-1:0]    res_id_q, res_id_d;
  logic [W-1:0]      res_data_q, res_data_d;

  logic              gnt_vld;
  logic [IDW-1:0]    gnt;
  logic [W-1:0]      x_g;
  logic [EW-1:0]     e_g;
  logic [2*W-1:0]    prod;
  int                idx;

  // Scan downward so the last hit wins: that is the first set bit at or above ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = IDW'(idx);
      end
    end
  end

  assign x_g  = x_in[int'(gnt)*W +: W];
  assign e_g  = exp_in[int'(gnt)*EW +: EW];
  assign prod = acc_q * base_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ack_d       = '0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          ack_d[gnt] = 1'b1;
          id_d       = gnt;
          base_d     = x_g;
          cnt_d      = e_g;
          acc_d      = (e_g == '0) ? W'(1) : x_g;
          ptr_d      = (int'(gnt) == NREQ-1) ? '0 : gnt + IDW'(1);
          state_d    = (e_g > EW'(1)) ? MULT : DONE;
        end
      end
      MULT: begin
        acc_d = prod[W-1:0];
        cnt_d = cnt_q - EW'(1);
        if (cnt_q == EW'(2)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered off the next state so they line up with it.
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    if (res_valid_d) begin
      res_id_d   = id_d;
      res_data_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_power_mult_scheduler.sv
// Bench for power_mult_scheduler: a job-timeline model checked every cycle,
// plus directed jobs with hand-computed results and arbitration orders.
module tb_power_mult_scheduler;
  localparam int NREQ = 4, W = 8, EW = 3, IDW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] x_in = '0;
  logic [NREQ*EW-1:0] exp_in = '0;
  logic [NREQ-1:0]   ack;
  logic              busy, res_valid;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_data;

  int checks = 0;
  int failures = 0;

  power_mult_scheduler #(.NREQ(NREQ), .W(W), .EW(EW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .exp_in(exp_in),
    .ack(ack), .busy(busy), .res_valid(res_valid), .res_id(res_id), .res_data(res_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int pw(input int x, input int e);
    int a = 1;
    for (int k = 0; k < e; k++) a = (a * x) & 255;
    return a;
  endfunction

  // Model: a job accepted at edge 1 with L=max(E,1) acks after edge 1, is busy
  // through edge L, pulses its result after edge L, and frees the block at edge L+1.
  bit m_on = 0, m_active = 0;
  int m_t, m_L, m_gid, m_res, m_ptr, m_rid, m_rdata;

  always @(negedge clk) begin
    bit idle_pre;
    int e, g;
    if (m_on) begin
      chk("ack",       int'(ack),       (m_active && m_t == 1) ? (1 << m_gid) : 0);
      chk("busy",      int'(busy),      int'(m_active && m_t <= m_L));
      chk("res_valid", int'(res_valid), int'(m_active && m_t == m_L));
      chk("res_id",    int'(res_id),    m_rid);
      chk("res_data",  int'(res_data),  m_rdata);
    end
    // Predict the coming edge from the inputs it will sample.
    if (rst) begin
      m_on = 1; m_active = 0; m_ptr = 0; m_rid = 0; m_rdata = 0; m_t = 0; m_L = 0;
    end else if (m_on) begin
      idle_pre = !m_active || m_t > m_L;
      if (m_active) m_t++;
      if (idle_pre && req != '0) begin
        g = -1;
        for (int k = 0; k < NREQ && g < 0; k++)
          if (req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        e = int'(exp_in[g*EW +: EW]);
        m_active = 1; m_t = 1; m_gid = g;
        m_L = (e < 1) ? 1 : e;
        m_res = pw(int'(x_in[g*W +: W]), e);
        m_ptr = (g + 1) % NREQ;
      end
      if (m_active && m_t == m_L) begin m_rid = m_gid; m_rdata = m_res; end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_job(input int i, input int x, input int e);
    x_in[i*W +: W]    = W'(x);
    exp_in[i*EW +: EW] = EW'(e);
  endtask

  task automatic run_job(input int i, input int x, input int e, input int exp_data);
    int n, lat;
    set_job(i, x, e);
    req[i] = 1'b1;
    n = 0;
    do begin tick; n++; end while (!ack[i] && n < 40);
    chk("ack_seen", int'(ack[i]), 1);
    req[i] = 1'b0;
    lat = 0;
    while (!res_valid && lat < 40) begin tick; lat++; end
    chk("res_latency", lat, ((e < 1) ? 1 : e) - 1);
    chk("res_id_direct", int'(res_id), i);
    chk("res_data_direct", int'(res_data), exp_data);
    tick;
    chk("res_pulse_len", int'(res_valid), 0);
    tick;
  endtask

  task automatic collect_order(input int nexp, output int ord[4]);
    int na = 0, n = 0;
    ord = '{-1, -1, -1, -1};
    while (!(na == nexp && !busy) && n < 200) begin
      tick; n++;
      for (int k = 0; k < NREQ; k++)
        if (ack[k]) begin
          if (na < 4) ord[na] = k;
          na++;
          req[k] = 1'b0;
        end
    end
    chk("ack_count", na, nexp);
    tick;
  endtask

  initial begin
    int ord[4];
    int nack2, nrv, n;
    // Model pins.
    chk("pw_3_3", pw(3, 3), 27);
    chk("pw_7_3", pw(7, 3), 87);
    chk("pw_3_7", pw(3, 7), 139);
    chk("pw_0_0", pw(0, 0), 1);
    chk("pw_0_3", pw(0, 3), 0);

    repeat (3) tick;
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_data", int'(res_data), 0);

    run_job(0, 3, 3, 27);
    run_job(1, 5, 0, 1);
    run_job(1, 200, 1, 200);
    run_job(2, 0, 0, 1);
    run_job(2, 0, 5, 0);
    run_job(0, 7, 3, 87);
    run_job(3, 3, 7, 139);
    run_job(1, 2, 7, 128);

    // Fresh reset so ptr=0, then all four contend.
    rst = 1'b1; tick; rst = 1'b0;
    set_job(0, 2, 2); set_job(1, 3, 2); set_job(2, 4, 2); set_job(3, 5, 2);
    req = 4'hF;
    collect_order(4, ord);
    chk("rr_0", ord[0], 0); chk("rr_1", ord[1], 1);
    chk("rr_2", ord[2], 2); chk("rr_3", ord[3], 3);
    run_job(0, 1, 1, 1);
    set_job(0, 6, 1); set_job(2, 9, 2);
    req = 4'b0101;
    collect_order(2, ord);
    chk("rr_ptr1_first", ord[0], 2); chk("rr_ptr1_second", ord[1], 0);

    // Reset lands on the third edge of an E=7 job.
    set_job(0, 2, 7);
    req[0] = 1'b1;
    n = 0;
    do begin tick; n++; end while (!ack[0] && n < 40);
    chk("abort_ack", int'(ack[0]), 1);
    req[0] = 1'b0;
    tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rv", int'(res_valid), 0);
    set_job(0, 4, 1); set_job(1, 5, 1);
    req = 4'b0011;
    collect_order(2, ord);
    chk("ptr_reset_first", ord[0], 0); chk("ptr_reset_second", ord[1], 1);
    run_job(3, 2, 2, 4);

    // Short req pulse while busy must never be granted.
    set_job(0, 3, 5); set_job(2, 11, 1);
    req[0] = 1'b1;
    n = 0;
    do begin tick; n++; end while (!ack[0] && n < 40);
    req[0] = 1'b0;
    req[2] = 1'b1;
    tick;
    req[2] = 1'b0;
    nack2 = 0; nrv = 0;
    for (int c = 0; c < 20; c++) begin
      if (ack[2]) nack2++;
      if (res_valid) begin nrv++; chk("busy_job_data", int'(res_data), 243); end
      tick;
    end
    chk("pulse_never_acked", nack2, 0);
    chk("single_result", nrv, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
